alu_op_sequencer: RTL and testbench

- Execute-stage controller that decodes one RV32 instruction per handshake and drives the ALU operand-A mux select, the operand-B mux select and the ALU function code.
- Sequences CSR read-modify-write instructions over three cycles: CSR read, ALU combine, CSR write.
- Sits between the decode stage (valid/ready in) and the writeback stage (valid/ready out).

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/alu_op_decode.sv | 64 ++++++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU control path: function codes,
// operand-mux selects, RV32 opcodes and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] FN_ADD    = 4'd0;
  localparam logic [3:0] FN_SUB    = 4'd1;
  localparam logic [3:0] FN_SLL    = 4'd2;
  localparam logic [3:0] FN_SLT    = 4'd3;
  localparam logic [3:0] FN_SLTU   = 4'd4;
  localparam logic [3:0] FN_XOR    = 4'd5;
  localparam logic [3:0] FN_SRL    = 4'd6;
  localparam logic [3:0] FN_SRA    = 4'd7;
  localparam logic [3:0] FN_OR     = 4'd8;
  localparam logic [3:0] FN_AND    = 4'd9;
  localparam logic [3:0] FN_PASS_A = 4'd10;
  localparam logic [3:0] FN_ANDN   = 4'd11;

  localparam logic [1:0] SEL_A_RS1   = 2'd0;
  localparam logic [1:0] SEL_A_IMM_U = 2'd1;
  localparam logic [1:0] SEL_A_IMM_Z = 2'd2;

  localparam logic [2:0] SEL_B_RS2   = 3'd0;
  localparam logic [2:0] SEL_B_IMM_I = 3'd1;
  localparam logic [2:0] SEL_B_IMM_S = 3'd2;
  localparam logic [2:0] SEL_B_PC    = 3'd3;
  localparam logic [2:0] SEL_B_CSR   = 3'd4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_CSR_RD = 2'd2,
    ST_CSR_WR = 2'd3
  } state_t;

  // CSR combine step: operand A is rs1 or zimm, operand B is the old CSR value.
  function automatic logic [1:0] csr_sel_a(input logic [2:0] funct3);
    return funct3[2] ? SEL_A_IMM_Z : SEL_A_RS1;
  endfunction

  function automatic logic [3:0] csr_fn(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b10:   return FN_OR;
      2'b11:   return FN_ANDN;
      default: return FN_PASS_A;
    endcase
  endfunction

  // Set/clear forms with a zero source leave the CSR untouched.
  function automatic logic csr_writes(input logic [2:0] funct3, input logic [4:0] rs1_field);
    return !(funct3[1] && (rs1_field == 5'd0));
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Decode-to-writeback bus of the ALU op sequencer.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1; valid and its payload hold until that edge, and ready may
// depend combinationally on the consumer's own downstream ready.
interface alu_op_sequencer_if #(
  parameter int ALU_FN_W  = 4,
  parameter int RS2_SEL_W = 3
);
  logic                 io_in_valid;
  logic                 io_in_ready;
  logic [6:0]           io_opcode;
  logic [2:0]           io_funct3;
  logic                 io_funct7_b5;
  logic [4:0]           io_rs1_field;
  logic [1:0]           io_rs1_mux_sel;
  logic [RS2_SEL_W-1:0] io_rs2_mux_sel;
  logic [ALU_FN_W-1:0]  io_alu_fn;
  logic                 io_csr_ren;
  logic                 io_csr_wen;
  logic                 io_out_valid;
  logic                 io_out_ready;
  logic                 io_out_csr_rd;
  logic                 io_illegal;

  modport slave (
    input  io_in_valid, io_opcode, io_funct3, io_funct7_b5, io_rs1_field, io_out_ready,
    output io_in_ready, io_rs1_mux_sel, io_rs2_mux_sel, io_alu_fn,
           io_csr_ren, io_csr_wen, io_out_valid, io_out_csr_rd, io_illegal
  );

  modport master (
    output io_in_valid, io_opcode, io_funct3, io_funct7_b5, io_rs1_field, io_out_ready,
    input  io_in_ready, io_rs1_mux_sel, io_rs2_mux_sel, io_alu_fn,
           io_csr_ren, io_csr_wen, io_out_valid, io_out_csr_rd, io_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: operand selects, ALU function, CSR and
// illegal-instruction flags for one RV32 instruction.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [1:0] sel_a,
  output logic [2:0] sel_b,
  output logic [3:0] fn,
  output logic       is_csr,
  output logic       illegal
);

  logic [3:0] arith_fn;

  // Shared register/immediate function table; SUB only exists for OP.
  always_comb begin
    arith_fn = FN_ADD;
    case (funct3)
      3'b000: arith_fn = (funct7_b5 && opcode == OPC_OP) ? FN_SUB : FN_ADD;
      3'b001: arith_fn = FN_SLL;
      3'b010: arith_fn = FN_SLT;
      3'b011: arith_fn = FN_SLTU;
      3'b100: arith_fn = FN_XOR;
      3'b101: arith_fn = funct7_b5 ? FN_SRA : FN_SRL;
      3'b110: arith_fn = FN_OR;
      3'b111: arith_fn = FN_AND;
      default: arith_fn = FN_ADD;
    endcase
  end

  always_comb begin
    sel_a   = SEL_A_RS1;
    sel_b   = SEL_B_RS2;
    fn      = FN_ADD;
    is_csr  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: fn = arith_fn;
      OPC_OP_IMM: begin
        sel_b = SEL_B_IMM_I;
        fn    = arith_fn;
      end
      OPC_LUI: begin
        sel_a = SEL_A_IMM_U;
        fn    = FN_PASS_A;
      end
      OPC_AUIPC: begin
        sel_a = SEL_A_IMM_U;
        sel_b = SEL_B_PC;
      end
      OPC_LOAD:  sel_b = SEL_B_IMM_I;
      OPC_STORE: sel_b = SEL_B_IMM_S;
      OPC_SYSTEM: begin
        if (funct3 != 3'b000) is_csr = 1'b1;
        else                  illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage controller: accepts one decoded instruction per handshake,
// registers the ALU controls and runs CSR read/combine/write sequences.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_FN_W  = 4,
  parameter int RS2_SEL_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output state_t              dbg_state
);

  state_t               state;
  logic [1:0]           rs1_sel;
  logic [RS2_SEL_W-1:0] rs2_sel;
  logic [ALU_FN_W-1:0]  alu_fn;
  logic                 csr_ren;
  logic                 csr_wen;
  logic                 out_valid;
  logic                 out_csr_rd;
  logic                 illegal;
  logic [2:0]           csr_funct3;
  logic [4:0]           csr_rs1;

  logic [1:0] dec_sel_a;
  logic [2:0] dec_sel_b;
  logic [3:0] dec_fn;
  logic       dec_is_csr;
  logic       dec_illegal;
  logic       in_ready;
  logic       accept;

  alu_op_decode u_decode (
    .opcode    (bus.io_opcode),
    .funct3    (bus.io_funct3),
    .funct7_b5 (bus.io_funct7_b5),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .fn        (dec_fn),
    .is_csr    (dec_is_csr),
    .illegal   (dec_illegal)
  );

  // EXEC frees its slot in the same cycle writeback takes the result.
  assign in_ready = (state == ST_IDLE) || (state == ST_EXEC && bus.io_out_ready);
  assign accept   = bus.io_in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rs1_sel    <= '0;
      rs2_sel    <= '0;
      alu_fn     <= '0;
      csr_ren    <= 1'b0;
      csr_wen    <= 1'b0;
      out_valid  <= 1'b0;
      out_csr_rd <= 1'b0;
      illegal    <= 1'b0;
      csr_funct3 <= '0;
      csr_rs1    <= '0;
    end else begin
      csr_ren <= 1'b0;
      csr_wen <= 1'b0;
      illegal <= 1'b0;
      if (accept) begin
        rs1_sel    <= dec_sel_a;
        rs2_sel    <= RS2_SEL_W'(dec_sel_b);
        alu_fn     <= ALU_FN_W'(dec_fn);
        out_csr_rd <= 1'b0;
        csr_funct3 <= bus.io_funct3;
        csr_rs1    <= bus.io_rs1_field;
        if (dec_illegal) begin
          illegal   <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end else if (dec_is_csr) begin
          csr_ren   <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_CSR_RD;
        end else begin
          out_valid <= 1'b1;
          state     <= ST_EXEC;
        end
      end else begin
        case (state)
          ST_EXEC: begin
            if (bus.io_out_ready) begin
              out_valid  <= 1'b0;
              out_csr_rd <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          // Combine controls and the write strobe land together in CSR_WR.
          ST_CSR_RD: begin
            rs1_sel <= csr_sel_a(csr_funct3);
            rs2_sel <= RS2_SEL_W'(SEL_B_CSR);
            alu_fn  <= ALU_FN_W'(csr_fn(csr_funct3));
            csr_wen <= csr_writes(csr_funct3, csr_rs1);
            state   <= ST_CSR_WR;
          end
          ST_CSR_WR: begin
            out_valid  <= 1'b1;
            out_csr_rd <= 1'b1;
            state      <= ST_EXEC;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.io_in_ready    = in_ready;
  assign bus.io_rs1_mux_sel = rs1_sel;
  assign bus.io_rs2_mux_sel = rs2_sel;
  assign bus.io_alu_fn      = alu_fn;
  assign bus.io_csr_ren     = csr_ren;
  assign bus.io_csr_wen     = csr_wen;
  assign bus.io_out_valid   = out_valid;
  assign bus.io_out_csr_rd  = out_csr_rd;
  assign bus.io_illegal     = illegal;
  assign dbg_state          = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with hand-computed expected controls.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic   clock;
  logic   reset;
  state_t dbg_state;
  int     total;
  int     bad;

  alu_op_sequencer_if #(.ALU_FN_W(4), .RS2_SEL_W(3)) bus ();

  alu_op_sequencer #(.ALU_FN_W(4), .RS2_SEL_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       b5;
    logic [1:0] a;
    logic [2:0] b;
    logic [3:0] fn;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [6:0] op, input logic [2:0] f3,
                       input logic b5, input logic [4:0] rs1);
    bus.io_in_valid  = valid;
    bus.io_opcode    = op;
    bus.io_funct3    = f3;
    bus.io_funct7_b5 = b5;
    bus.io_rs1_field = rs1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sel_a"}, 32'(bus.io_rs1_mux_sel), 32'd0);
    chk({tag, "_sel_b"}, 32'(bus.io_rs2_mux_sel), 32'd0);
    chk({tag, "_fn"}, 32'(bus.io_alu_fn), 32'd0);
    chk({tag, "_ren"}, 32'(bus.io_csr_ren), 32'd0);
    chk({tag, "_wen"}, 32'(bus.io_csr_wen), 32'd0);
    chk({tag, "_valid"}, 32'(bus.io_out_valid), 32'd0);
    chk({tag, "_csr_rd"}, 32'(bus.io_out_csr_rd), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.io_illegal), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.io_in_ready), 32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{OPC_OP,     3'b010, 1'b0, 2'd0, 3'd0, 4'd3};  // SLT
    vecs[1] = '{OPC_OP,     3'b101, 1'b1, 2'd0, 3'd0, 4'd7};  // SRA
    vecs[2] = '{OPC_OP,     3'b111, 1'b0, 2'd0, 3'd0, 4'd9};  // AND
    vecs[3] = '{OPC_OP_IMM, 3'b101, 1'b1, 2'd0, 3'd1, 4'd7};  // SRAI
    vecs[4] = '{OPC_OP_IMM, 3'b000, 1'b1, 2'd0, 3'd1, 4'd0};  // ADDI, b5 ignored
    vecs[5] = '{OPC_AUIPC,  3'b000, 1'b0, 2'd1, 3'd3, 4'd0};
    vecs[6] = '{OPC_LOAD,   3'b010, 1'b0, 2'd0, 3'd1, 4'd0};
    vecs[7] = '{OPC_STORE,  3'b010, 1'b0, 2'd0, 3'd2, 4'd0};
    vecs[8] = '{OPC_LUI,    3'b000, 1'b0, 2'd1, 3'd0, 4'd10};

    reset = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    bus.io_out_ready = 1'b1;
    #12;
    chk_zero_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // LUI from IDLE
    drive(1'b1, OPC_LUI, 3'd0, 1'b0, 5'd0);
    chk("lui_in_ready", 32'(bus.io_in_ready), 32'd1);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    chk("lui_sel_a", 32'(bus.io_rs1_mux_sel), 32'd1);
    chk("lui_fn", 32'(bus.io_alu_fn), 32'd10);
    chk("lui_valid", 32'(bus.io_out_valid), 32'd1);
    chk("lui_state", 32'(dbg_state), 32'd1);
    tick();
    chk("lui_idle_valid", 32'(bus.io_out_valid), 32'd0);
    chk("lui_idle_state", 32'(dbg_state), 32'd0);

    // ADD then SUB back-to-back
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 5'd1);
    tick();
    chk("add_fn", 32'(bus.io_alu_fn), 32'd0);
    chk("add_valid", 32'(bus.io_out_valid), 32'd1);
    drive(1'b1, OPC_OP, 3'b000, 1'b1, 5'd1);
    chk("sub_in_ready", 32'(bus.io_in_ready), 32'd1);
    tick();
    chk("sub_fn", 32'(bus.io_alu_fn), 32'd1);
    chk("sub_valid", 32'(bus.io_out_valid), 32'd1);

    // Directed vector table, all back-to-back
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].b5, 5'd3);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.io_in_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_sel_a", i), 32'(bus.io_rs1_mux_sel), 32'(vecs[i].a));
      chk($sformatf("vec%0d_sel_b", i), 32'(bus.io_rs2_mux_sel), 32'(vecs[i].b));
      chk($sformatf("vec%0d_fn", i), 32'(bus.io_alu_fn), 32'(vecs[i].fn));
      chk($sformatf("vec%0d_valid", i), 32'(bus.io_out_valid), 32'd1);
    end
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    tick();
    chk("vec_idle", 32'(dbg_state), 32'd0);

    // CSRRSI with zimm = 0: no write strobe
    drive(1'b1, OPC_SYSTEM, 3'b110, 1'b0, 5'd0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    chk("csrrsi_ren", 32'(bus.io_csr_ren), 32'd1);
    chk("csrrsi_rd_valid", 32'(bus.io_out_valid), 32'd0);
    chk("csrrsi_rd_in_ready", 32'(bus.io_in_ready), 32'd0);
    chk("csrrsi_rd_state", 32'(dbg_state), 32'd2);
    tick();
    chk("csrrsi_wr_ren", 32'(bus.io_csr_ren), 32'd0);
    chk("csrrsi_sel_a", 32'(bus.io_rs1_mux_sel), 32'd2);
    chk("csrrsi_sel_b", 32'(bus.io_rs2_mux_sel), 32'd4);
    chk("csrrsi_fn", 32'(bus.io_alu_fn), 32'd8);
    chk("csrrsi_wen", 32'(bus.io_csr_wen), 32'd0);
    chk("csrrsi_wr_in_ready", 32'(bus.io_in_ready), 32'd0);
    tick();
    chk("csrrsi_valid", 32'(bus.io_out_valid), 32'd1);
    chk("csrrsi_csr_rd", 32'(bus.io_out_csr_rd), 32'd1);
    chk("csrrsi_exec_wen", 32'(bus.io_csr_wen), 32'd0);
    tick();
    chk("csrrsi_idle_csr_rd", 32'(bus.io_out_csr_rd), 32'd0);
    chk("csrrsi_idle_state", 32'(dbg_state), 32'd0);

    // CSRRW rs1 = 5: one write pulse
    drive(1'b1, OPC_SYSTEM, 3'b001, 1'b0, 5'd5);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    chk("csrrw_ren", 32'(bus.io_csr_ren), 32'd1);
    chk("csrrw_rd_wen", 32'(bus.io_csr_wen), 32'd0);
    tick();
    chk("csrrw_wen", 32'(bus.io_csr_wen), 32'd1);
    chk("csrrw_wr_ren", 32'(bus.io_csr_ren), 32'd0);
    chk("csrrw_sel_a", 32'(bus.io_rs1_mux_sel), 32'd0);
    chk("csrrw_sel_b", 32'(bus.io_rs2_mux_sel), 32'd4);
    chk("csrrw_fn", 32'(bus.io_alu_fn), 32'd10);
    tick();
    chk("csrrw_exec_wen", 32'(bus.io_csr_wen), 32'd0);
    chk("csrrw_valid", 32'(bus.io_out_valid), 32'd1);
    chk("csrrw_csr_rd", 32'(bus.io_out_csr_rd), 32'd1);
    tick();
    chk("csrrw_idle", 32'(dbg_state), 32'd0);

    // Backpressure on ORI
    bus.io_out_ready = 1'b0;
    drive(1'b1, OPC_OP_IMM, 3'b110, 1'b0, 5'd2);
    tick();
    drive(1'b1, OPC_OP, 3'b000, 1'b1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d_in_ready", i), 32'(bus.io_in_ready), 32'd0);
      chk($sformatf("bp%0d_sel_a", i), 32'(bus.io_rs1_mux_sel), 32'd0);
      chk($sformatf("bp%0d_sel_b", i), 32'(bus.io_rs2_mux_sel), 32'd1);
      chk($sformatf("bp%0d_fn", i), 32'(bus.io_alu_fn), 32'd8);
      chk($sformatf("bp%0d_valid", i), 32'(bus.io_out_valid), 32'd1);
      chk($sformatf("bp%0d_state", i), 32'(dbg_state), 32'd1);
      tick();
    end
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    bus.io_out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.io_out_valid), 32'd0);
    chk("bp_release_state", 32'(dbg_state), 32'd0);

    // Illegal FENCE opcode, then LUI accepted the next cycle
    drive(1'b1, 7'b0001111, 3'd0, 1'b0, 5'd0);
    tick();
    chk("fence_illegal", 32'(bus.io_illegal), 32'd1);
    chk("fence_valid", 32'(bus.io_out_valid), 32'd0);
    chk("fence_state", 32'(dbg_state), 32'd0);
    drive(1'b1, OPC_LUI, 3'd0, 1'b0, 5'd0);
    chk("fence_in_ready", 32'(bus.io_in_ready), 32'd1);
    tick();
    chk("fence_pulse_end", 32'(bus.io_illegal), 32'd0);
    chk("after_fence_valid", 32'(bus.io_out_valid), 32'd1);
    chk("after_fence_fn", 32'(bus.io_alu_fn), 32'd10);
    // SYSTEM with funct3 = 0 is illegal too, loaded back-to-back from EXEC
    drive(1'b1, OPC_SYSTEM, 3'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    chk("ecall_illegal", 32'(bus.io_illegal), 32'd1);
    chk("ecall_valid", 32'(bus.io_out_valid), 32'd0);
    chk("ecall_ren", 32'(bus.io_csr_ren), 32'd0);
    tick();
    chk("ecall_pulse_end", 32'(bus.io_illegal), 32'd0);

    // Reset asserted during CSR_WR
    drive(1'b1, OPC_SYSTEM, 3'b001, 1'b0, 5'd5);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0);
    tick();
    chk("rst_pre_wen", 32'(bus.io_csr_wen), 32'd1);
    chk("rst_pre_state", 32'(dbg_state), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_after%0d_wen", i), 32'(bus.io_csr_wen), 32'd0);
      chk($sformatf("rst_after%0d_valid", i), 32'(bus.io_out_valid), 32'd0);
      chk($sformatf("rst_after%0d_in_ready", i), 32'(bus.io_in_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
